rv32i_dmem_responder: RTL and testbench

RV32I_DMEM_RESPONDER -- requirements
Module: rv32i_dmem_responder

---
 rtl/rv32i_dmem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_rv32i_dmem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder for an RV32I MEM stage: one access at a time, a fixed
// wait-state latency, byte/half/word loads and stores, and rejection of illegal accesses.
module rv32i_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        busy_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_C = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t          state_r, state_n_s;
  logic [3:0]      cnt_r;
  logic [AW+1:0]   addr_r;
  logic [31:0]     wdata_r;
  logic [2:0]      funct3_r;
  logic            re_r, we_r;
  logic [31:0]     mem_r [DEPTH_WORDS];
  logic [31:0]     rdata_r;
  logic            ready_r, err_r, busy_r;

  logic            cur_re_s, cur_we_s, cur_err_s;
  logic [AW+1:0]   cur_addr_s;
  logic [2:0]      cur_funct3_s;
  logic [31:0]     rd_word_s, load_val_s, wr_lanes_s;
  logic [3:0]      be_s;
  logic            wr_en_s;
  logic            unused_addr_s;

  // Address bits above the array index alias onto the same words.
  assign unused_addr_s = ^addr_i[31:AW+2];

  function automatic logic access_err(input logic re, input logic we,
                                      input logic [2:0] f3, input logic [1:0] a);
    logic e;
    e = 1'b0;
    if (re && we) begin
      e = 1'b1;
    end else begin
      case (f3)
        3'b000:  e = 1'b0;
        3'b001:  e = a[0];
        3'b010:  e = (a != 2'b00);
        3'b100:  e = we;
        3'b101:  e = we | a[0];
        default: e = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << a;
      3'b001:  be = a[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // In IDLE the live inputs describe the access (needed when WAIT_STATES=0); afterwards the captured copy does.
  always_comb begin
    cur_re_s     = re_r;
    cur_we_s     = we_r;
    cur_addr_s   = addr_r;
    cur_funct3_s = funct3_r;
    if (state_r == S_IDLE) begin
      cur_re_s     = mem_re_i;
      cur_we_s     = mem_we_i;
      cur_addr_s   = addr_i[AW+1:0];
      cur_funct3_s = funct3_i;
    end else begin
      cur_re_s     = re_r;
    end
    cur_err_s  = access_err(cur_re_s, cur_we_s, cur_funct3_s, cur_addr_s[1:0]);
    rd_word_s  = mem_r[cur_addr_s[AW+1:2]];
    load_val_s = cur_err_s ? 32'd0 : load_extend(rd_word_s, cur_funct3_s, cur_addr_s[1:0]);
    be_s       = byte_en(funct3_r, addr_r[1:0]);
    wr_en_s    = (state_r == S_RESP) && we_r && !cur_err_s;
    case (funct3_r)
      3'b000:  wr_lanes_s = {4{wdata_r[7:0]}};
      3'b001:  wr_lanes_s = {2{wdata_r[15:0]}};
      default: wr_lanes_s = wdata_r;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (mem_re_i || mem_we_i) begin
          state_n_s = (WS_C != 4'd0) ? S_WAIT : S_RESP;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_n_s = S_RESP;
        end else begin
          state_n_s = S_WAIT;
        end
      end
      S_RESP:  state_n_s = S_IDLE;
      default: state_n_s = S_IDLE;
    endcase
  end

  // State, wait counter and request capture.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_r  <= S_IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= '0;
      wdata_r  <= 32'd0;
      funct3_r <= 3'd0;
      re_r     <= 1'b0;
      we_r     <= 1'b0;
    end else begin
      state_r <= state_n_s;
      if (state_r == S_IDLE && (mem_re_i || mem_we_i)) begin
        cnt_r    <= WS_C;
        addr_r   <= addr_i[AW+1:0];
        wdata_r  <= wdata_i;
        funct3_r <= funct3_i;
        re_r     <= mem_re_i;
        we_r     <= mem_we_i;
      end else if (state_r == S_WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= 4'd0;
      end
    end
  end

  // Registered handshake outputs; load data is latched on the edge entering RESP.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      ready_r <= (state_n_s == S_RESP);
      err_r   <= (state_n_s == S_RESP) && cur_err_s;
      busy_r  <= (state_n_s != S_IDLE);
      if (state_n_s == S_RESP && cur_re_s) begin
        rdata_r <= load_val_s;
      end
    end
  end

  // Store commits on the edge leaving RESP; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_s && be_s[i]) begin
        mem_r[addr_r[AW+1:2]][8*i +: 8] <= wr_lanes_s[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_r;
  assign ready_o = ready_r;
  assign err_o   = err_r;
  assign busy_o  = busy_r;
endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Scoreboard bench: two responders (WAIT_STATES=1 and WAIT_STATES=0) driven with
// byte/half/word accesses, rejected accesses, aliasing and a mid-access reset.
module tb_rv32i_dmem_responder;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        resetn;
  logic        re [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [2:0]  f3 [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err [2];
  logic        busy [2];

  always #5 clk = ~clk;

  rv32i_dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) dut_ws1 (
    .clk_i(clk), .resetn_i(resetn), .mem_re_i(re[0]), .mem_we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .funct3_i(f3[0]), .rdata_o(rdata[0]), .ready_o(ready[0]),
    .err_o(err[0]), .busy_o(busy[0]));

  rv32i_dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_ws0 (
    .clk_i(clk), .resetn_i(resetn), .mem_re_i(re[1]), .mem_we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .funct3_i(f3[1]), .rdata_o(rdata[1]), .ready_o(ready[1]),
    .err_o(err[1]), .busy_o(busy[1]));

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    bit          chk_rdata;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_rd [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input int k);
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : q1.size();
    check_eq($sformatf("dut%0d_sb_nonempty", k), 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      check_eq({e.tag, "_err"}, 32'(err[k]), 32'(e.err));
      if (e.chk_rdata) check_eq({e.tag, "_rdata"}, rdata[k], e.rdata);
    end
  endtask

  // Scoreboard side: every ready pulse consumes one expected response.
  always @(negedge clk) begin
    if (ready[0] === 1'b1) sb_pop(0);
    if (ready[1] === 1'b1) sb_pop(1);
  end

  task automatic access(input int k, input bit rq_re, input bit rq_we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] fn, input logic [31:0] exp_rd,
                        input bit exp_err, input bit chk, input bit toggle, input string tag);
    exp_t e;
    int   cyc;
    e = '{tag: tag, rdata: exp_rd, err: exp_err, chk_rdata: chk};
    @(negedge clk);
    re[k] = rq_re; we[k] = rq_we; addr[k] = a; wdata[k] = wd; f3[k] = fn;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      check_eq({tag, "_busy"}, 32'(busy[k]), 32'd1);
      if (toggle) begin
        re[k] = ~re[k]; we[k] = ~we[k]; wdata[k] = ~wdata[k];
      end
    end while (ready[k] !== 1'b1 && cyc < 20);
    check_eq({tag, "_latency"}, cyc, (k == 0) ? 32'd2 : 32'd1);
    re[k] = 1'b0; we[k] = 1'b0;
    @(negedge clk);
    check_eq({tag, "_ready_pulse"}, 32'(ready[k]), 32'd0);
    check_eq({tag, "_idle_busy"}, 32'(busy[k]), 32'd0);
  endtask

  task automatic ld(input int k, input logic [31:0] a, input logic [2:0] fn,
                    input logic [31:0] exp_rd, input bit exp_err, input string tag);
    access(k, 1'b1, 1'b0, a, 32'd0, fn, exp_rd, exp_err, 1'b1, 1'b0, tag);
    last_rd[k] = exp_rd;
  endtask

  task automatic st(input int k, input logic [31:0] a, input logic [31:0] wd,
                    input logic [2:0] fn, input bit exp_err, input string tag);
    access(k, 1'b0, 1'b1, a, wd, fn, last_rd[k], exp_err, 1'b1, 1'b0, tag);
  endtask

  initial begin
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      re[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0; f3[k] = 3'd0;
      last_rd[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst%0d_ready", k), 32'(ready[k]), 32'd0);
      check_eq($sformatf("rst%0d_err", k), 32'(err[k]), 32'd0);
      check_eq($sformatf("rst%0d_busy", k), 32'(busy[k]), 32'd0);
      check_eq($sformatf("rst%0d_rdata", k), rdata[k], 32'd0);
    end
    @(posedge clk);
    #1 resetn = 1'b1;

    st(0, 32'h10, 32'hDEADBEEF, F_W, 1'b0, "sw_10");
    ld(0, 32'h10, F_W, 32'hDEADBEEF, 1'b0, "lw_10");
    st(0, 32'h13, 32'h00000080, F_B, 1'b0, "sb_13");
    ld(0, 32'h13, F_B, 32'hFFFFFF80, 1'b0, "lb_13");
    ld(0, 32'h13, F_BU, 32'h00000080, 1'b0, "lbu_13");
    ld(0, 32'h10, F_W, 32'h80ADBEEF, 1'b0, "lw_10_merged");
    ld(0, 32'h12, F_W, 32'h00000000, 1'b1, "lw_misaligned");
    st(0, 32'h11, 32'h00005555, F_H, 1'b1, "sh_misaligned");
    ld(0, 32'h10, F_W, 32'h80ADBEEF, 1'b0, "lw_after_bad_sh");
    access(0, 1'b1, 1'b1, 32'h10, 32'h00000000, F_W, 32'd0, 1'b1, 1'b0, 1'b0, "re_we_both");
    ld(0, 32'h10, F_W, 32'h80ADBEEF, 1'b0, "lw_after_both");
    access(0, 1'b1, 1'b0, 32'h10, 32'h00000000, F_W, 32'h80ADBEEF, 1'b0, 1'b1, 1'b1, "lw_toggled");
    ld(0, 32'h10, F_W, 32'h80ADBEEF, 1'b0, "lw_after_toggle");
    ld(0, 32'h10, 3'b011, 32'h00000000, 1'b1, "ld_f3_011");
    st(0, 32'h10, 32'h00000000, F_BU, 1'b1, "st_f3_100");
    ld(0, 32'h10, F_W, 32'h80ADBEEF, 1'b0, "lw_after_bad_st");
    st(0, 32'h14, 32'h11223344, F_W, 1'b0, "sw_14");
    st(0, 32'h16, 32'h0000A5A5, F_H, 1'b0, "sh_16");
    ld(0, 32'h16, F_H, 32'hFFFFA5A5, 1'b0, "lh_16");
    ld(0, 32'h16, F_HU, 32'h0000A5A5, 1'b0, "lhu_16");
    ld(0, 32'h15, F_B, 32'h00000033, 1'b0, "lb_15");
    ld(0, 32'h14, F_W, 32'hA5A53344, 1'b0, "lw_14");
    ld(0, 32'h15, F_HU, 32'h00000000, 1'b1, "lhu_misaligned");

    st(0, 32'h20, 32'h0BADF00D, F_W, 1'b0, "sw_20_pre");
    ld(0, 32'h20, F_W, 32'h0BADF00D, 1'b0, "lw_20_pre");
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hFFFFFFFF; f3[0] = F_W;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_busy_before", 32'(busy[0]), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("abort_ready", 32'(ready[0]), 32'd0);
    check_eq("abort_err", 32'(err[0]), 32'd0);
    check_eq("abort_busy", 32'(busy[0]), 32'd0);
    check_eq("abort_rdata", rdata[0], 32'd0);
    we[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("abort_no_ready", 32'(ready[0]), 32'd0);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    ld(0, 32'h20, F_W, 32'h0BADF00D, 1'b0, "lw_20_after_abort");

    st(1, 32'h400, 32'h00001234, F_W, 1'b0, "ws0_sw_400");
    ld(1, 32'h0, F_W, 32'h00001234, 1'b0, "ws0_lw_0_wrap");
    ld(1, 32'hFFFFFC00, F_W, 32'h00001234, 1'b0, "ws0_lw_hi_wrap");
    st(1, 32'h8, 32'hCAFEF00D, F_W, 1'b0, "ws0_sw_8");
    ld(1, 32'h8, F_W, 32'hCAFEF00D, 1'b0, "ws0_lw_8");
    ld(1, 32'h9, F_H, 32'h00000000, 1'b1, "ws0_lh_misaligned");

    repeat (2) @(negedge clk);
    check_eq("sb_drained_0", q0.size(), 32'd0);
    check_eq("sb_drained_1", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
